// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared error type, error bit positions and sizing helper for sync_fifo_prog
package sync_fifo_pkg;

  typedef struct packed {
    logic underflow;
    logic overflow;
  } fifo_err_t;

  localparam int ERR_OVF_BIT = 0;
  localparam int ERR_UDF_BIT = 1;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: DEPTH x WIDTH storage, one write port, registered or asynchronous read port
module sync_fifo_ram #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter bit REG_RD     = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [WIDTH-1:0]      rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i)
    if (we_i) mem[waddr_i] <= wdata_i;

  if (REG_RD) begin : g_reg
    always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) rdata_o <= '0;
      else if (re_i) rdata_o <= mem[raddr_i];
  end else begin : g_async
    logic unused_ctl;
    assign unused_ctl = rst_i ^ re_i;
    assign rdata_o = mem[raddr_i];
  end

endmodule

// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: synchronous FIFO with fill count, programmable almost flags and sticky errors
// define SYNC_FIFO_FWFT_EN for first-word-fall-through reads
module sync_fifo_prog
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter int ADDR_WIDTH = clog2_min1(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  wr_en_i,
  input  logic                  rd_en_i,
  input  logic                  err_clr_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  almost_empty_o,
  output logic                  almost_full_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  error_o,
  output logic [1:0]            err_code_o
);

  localparam logic [ADDR_WIDTH:0] AF_L = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_L = (ADDR_WIDTH+1)'(AE_LEVEL);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "sync_fifo_prog: DEPTH must be a power of 2 and at least 4");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $fatal(1, "sync_fifo_prog: AF_LEVEL must be in 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $fatal(1, "sync_fifo_prog: AE_LEVEL must be in 0..DEPTH-1");
  end

  logic [ADDR_WIDTH:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n, count_n;
  logic [WIDTH-1:0]    ram_rdata;
  logic                rd_acc, wr_acc, ovf, udf;
  fifo_err_t           err_q, err_n;

`ifdef SYNC_FIFO_FWFT_EN
  localparam bit REG_RD = 1'b0;
  logic [WIDTH-1:0] hold_q;
  // last displayed word is kept so rdata_o stays stable once the FIFO drains
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) hold_q <= '0;
    else if (~empty_o) hold_q <= ram_rdata;
  assign rdata_o = empty_o ? hold_q : ram_rdata;
`else
  localparam bit REG_RD = 1'b1;
  assign rdata_o = ram_rdata;
`endif

  always_comb begin
    rd_acc          = rd_en_i & ~empty_o;
    wr_acc          = wr_en_i & (~full_o | rd_acc);
    ovf             = wr_en_i & full_o & ~rd_acc;
    udf             = rd_en_i & empty_o;
    wr_ptr_n        = wr_ptr + (ADDR_WIDTH+1)'(wr_acc);
    rd_ptr_n        = rd_ptr + (ADDR_WIDTH+1)'(rd_acc);
    count_n         = count_o + (ADDR_WIDTH+1)'(wr_acc) - (ADDR_WIDTH+1)'(rd_acc);
    err_n.overflow  = ovf | (err_q.overflow & ~err_clr_i);
    err_n.underflow = udf | (err_q.underflow & ~err_clr_i);
  end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count_o        <= '0;
      empty_o        <= 1'b1;
      full_o         <= 1'b0;
      almost_empty_o <= 1'b1;
      almost_full_o  <= 1'b0;
      err_q          <= '0;
      error_o        <= 1'b0;
    end else begin
      wr_ptr         <= wr_ptr_n;
      rd_ptr         <= rd_ptr_n;
      count_o        <= count_n;
      empty_o        <= wr_ptr_n == rd_ptr_n;
      full_o         <= wr_ptr_n == {~rd_ptr_n[ADDR_WIDTH], rd_ptr_n[ADDR_WIDTH-1:0]};
      almost_empty_o <= count_n <= AE_L;
      almost_full_o  <= count_n >= AF_L;
      err_q          <= err_n;
      error_o        <= |err_n;
    end

  assign err_code_o = err_q;

  sync_fifo_ram #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .REG_RD     (REG_RD)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata_i (wdata_i),
    .re_i    (rd_acc),
    .raddr_i (rd_ptr[ADDR_WIDTH-1:0]),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb_sync_fifo_prog: randomized and directed checks of sync_fifo_prog against a queue model
module tb_sync_fifo_prog;

  localparam int D = 8;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       wr_en_i = 1'b0, rd_en_i = 1'b0, err_clr_i = 1'b0;
  logic [7:0] wdata_i = '0, rdata_o;
  logic       empty_o, full_o, almost_empty_o, almost_full_o, error_o;
  logic [3:0] count_o;
  logic [1:0] err_code_o;

  int checks = 0, errors = 0;

  logic [7:0] q[$];
  logic [7:0] m_rdata = '0;
  logic [1:0] m_err = '0;

  always #5 clk_i = ~clk_i;

  sync_fifo_prog #(.WIDTH(8), .DEPTH(D), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .wdata_i        (wdata_i),
    .wr_en_i        (wr_en_i),
    .rd_en_i        (rd_en_i),
    .err_clr_i      (err_clr_i),
    .rdata_o        (rdata_o),
    .empty_o        (empty_o),
    .full_o         (full_o),
    .almost_empty_o (almost_empty_o),
    .almost_full_o  (almost_full_o),
    .count_o        (count_o),
    .error_o        (error_o),
    .err_code_o     (err_code_o)
  );

  function automatic logic [18:0] exp_vec();
    int n = q.size();
    return {4'(n), n == 0, n == D, n <= 2, n >= 6, |m_err, m_err, m_rdata};
  endfunction

  function automatic logic [18:0] dut_vec();
    return {count_o, empty_o, full_o, almost_empty_o, almost_full_o, error_o, err_code_o, rdata_o};
  endfunction

  task automatic model_reset();
    q.delete();
    m_rdata = '0;
    m_err = '0;
  endtask

  task automatic step(input logic wr, input logic rd, input logic [7:0] d, input logic clr);
    bit ra, wa;
    wr_en_i = wr;
    rd_en_i = rd;
    wdata_i = d;
    err_clr_i = clr;
    @(posedge clk_i);
    ra = rd && q.size() != 0;
    wa = wr && (q.size() != D || ra);
    if (clr) m_err = '0;
    if (wr && q.size() == D && !ra) m_err[0] = 1'b1;
    if (rd && q.size() == 0) m_err[1] = 1'b1;
    if (ra) m_rdata = q.pop_front();
    if (wa) q.push_back(d);
`ifdef SYNC_FIFO_FWFT_EN
    if (q.size() != 0) m_rdata = q[0];
`endif
    #1;
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
    err_clr_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    model_reset();
    checks++;
    if (dut_vec() !== 19'b0000_1_0_1_0_0_00_00000000) begin
      errors++;
      $display("FAIL reset_state: got %h want %h", dut_vec(), 19'b0000_1_0_1_0_0_00_00000000);
    end
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 8'(8'h11 + i), 1'b0);
      checks++;
      if ({count_o, almost_empty_o, almost_full_o, full_o, error_o} !==
          {4'(i + 1), (i + 1) <= 2, (i + 1) >= 6, (i + 1) == 8, 1'b0}) begin
        errors++;
        $display("FAIL fill_%0d: got cnt=%0d ae=%b af=%b full=%b err=%b want cnt=%0d",
                 i, count_o, almost_empty_o, almost_full_o, full_o, error_o, i + 1);
      end
    end
  endtask

  task automatic test_overflow();
    step(1'b1, 1'b0, 8'hAA, 1'b0);
    checks++;
    if ({count_o, error_o, err_code_o} !== {4'd8, 1'b1, 2'b01}) begin
      errors++;
      $display("FAIL overflow: got cnt=%0d err=%b code=%b want cnt=8 err=1 code=01",
               count_o, error_o, err_code_o);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 8'h00, 1'b0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL drain_%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
`ifndef SYNC_FIFO_FWFT_EN
      checks++;
      if (rdata_o !== 8'(8'h11 + i)) begin
        errors++;
        $display("FAIL drain_data_%0d: got %h want %h", i, rdata_o, 8'(8'h11 + i));
      end
`endif
    end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    if ({error_o, err_code_o} !== 3'b000) begin
      errors++;
      $display("FAIL ovf_clear: got err=%b code=%b want 0/00", error_o, err_code_o);
    end
  endtask

  task automatic test_underflow();
    step(1'b0, 1'b1, 8'h00, 1'b0);
    checks++;
    if ({error_o, err_code_o, rdata_o, count_o} !== {1'b1, 2'b10, 8'h18, 4'd0}) begin
      errors++;
      $display("FAIL underflow: got err=%b code=%b rdata=%h cnt=%0d want 1/10/18/0",
               error_o, err_code_o, rdata_o, count_o);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    if ({error_o, err_code_o} !== 3'b000) begin
      errors++;
      $display("FAIL udf_clear: got err=%b code=%b want 0/00", error_o, err_code_o);
    end
    step(1'b0, 1'b1, 8'h00, 1'b1);
    checks++;
    if ({error_o, err_code_o} !== 3'b110) begin
      errors++;
      $display("FAIL clear_vs_new: got err=%b code=%b want 1/10", error_o, err_code_o);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL udf_reclear: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_full_rdwr();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0);
    checks++;
    if ({full_o, count_o} !== {1'b1, 4'd8}) begin
      errors++;
      $display("FAIL refill: got full=%b cnt=%0d want 1/8", full_o, count_o);
    end
    step(1'b1, 1'b1, 8'h55, 1'b0);
    checks++;
    if ({count_o, full_o, error_o, err_code_o} !== {4'd8, 1'b1, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL full_rdwr: got cnt=%0d full=%b err=%b code=%b want 8/1/0/00",
               count_o, full_o, error_o, err_code_o);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 8'h00, 1'b0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL full_rdwr_drain_%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    checks++;
    if ({rdata_o, empty_o} !== {8'h55, 1'b1}) begin
      errors++;
      $display("FAIL full_rdwr_last: got rdata=%h empty=%b want 55/1", rdata_o, empty_o);
    end
  endtask

  task automatic test_random();
    int wr_bias;
    for (int i = 0; i < 240; i++) begin
      wr_bias = ((i / 40) % 2 == 0) ? 75 : 30;
      step($urandom_range(0, 99) < wr_bias, $urandom_range(0, 99) < 100 - wr_bias,
           8'($urandom), $urandom_range(0, 15) == 0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random_%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    while (q.size() != 0) step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL random_drain: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_empty_rdwr();
    step(1'b1, 1'b1, 8'h77, 1'b0);
    checks++;
    if ({count_o, empty_o, error_o, err_code_o} !== {4'd1, 1'b0, 1'b1, 2'b10}) begin
      errors++;
      $display("FAIL empty_rdwr: got cnt=%0d empty=%b err=%b code=%b want 1/0/1/10",
               count_o, empty_o, error_o, err_code_o);
    end
    step(1'b0, 1'b1, 8'h00, 1'b1);
    checks++;
    if ({rdata_o, count_o, error_o, err_code_o} !== {8'h77, 4'd0, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL empty_rdwr_pop: got rdata=%h cnt=%0d err=%b code=%b want 77/0/0/00",
               rdata_o, count_o, error_o, err_code_o);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'($urandom), 1'b0);
    checks++;
    if (count_o !== 4'd5) begin
      errors++;
      $display("FAIL pre_reset_count: got %0d want 5", count_o);
    end
    rst_i = 1'b1;
    #1;
    model_reset();
    checks++;
    if (dut_vec() !== 19'b0000_1_0_1_0_0_00_00000000) begin
      errors++;
      $display("FAIL reset_mid: got %h want %h", dut_vec(), 19'b0000_1_0_1_0_0_00_00000000);
    end
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    step(1'b0, 1'b1, 8'h00, 1'b0);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL post_reset_read: got %h want %h", dut_vec(), exp_vec());
    end
    step(1'b0, 1'b0, 8'h00, 1'b1);
  endtask

`ifdef SYNC_FIFO_FWFT_EN
  task automatic test_fwft();
    step(1'b1, 1'b0, 8'h3C, 1'b0);
    checks++;
    if ({rdata_o, empty_o} !== {8'h3C, 1'b0}) begin
      errors++;
      $display("FAIL fwft_show: got rdata=%h empty=%b want 3c/0", rdata_o, empty_o);
    end
    step(1'b0, 1'b1, 8'h00, 1'b0);
    checks++;
    if ({rdata_o, empty_o, error_o} !== {8'h3C, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL fwft_pop: got rdata=%h empty=%b err=%b want 3c/1/0", rdata_o, empty_o, error_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_underflow();
    test_full_rdwr();
    test_random();
    test_empty_rdwr();
    test_reset_mid();
`ifdef SYNC_FIFO_FWFT_EN
    test_fwft();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
Parametrised synchronous FIFO, successor to the fixed-size FIFO behind the existing fifo_intf bench. It adds a fill-level count, programmable almost-full/almost-empty flags, and overflow/underflow error reporting with a sticky cause code and software clear. It sits between single-clock producer/consumer blocks and is driven and monitored through an extended interface that uses the same signal names.

Parameters:
- WIDTH, 8: data word width in bits.
- DEPTH, 16: number of entries; must be a power of 2 and at least 4.
- AF_LEVEL, DEPTH-2: almost_full_o asserts when count >= AF_LEVEL.
- AE_LEVEL, 2: almost_empty_o asserts when count <= AE_LEVEL.
- ADDR_WIDTH, $clog2(DEPTH): derived; do not override.

Ports:
- clk_i, in, 1: clock, rising edge.
- rst_i, in, 1: reset, asynchronous, active-high.
- wdata_i, in, WIDTH: write data.
- wr_en_i, in, 1: write request.
- rd_en_i, in, 1: read request.
- err_clr_i, in, 1: clears error_o and err_code_o.
- rdata_o, out, WIDTH: read data.
- empty_o, out, 1: FIFO empty.
- full_o, out, 1: FIFO full.
- almost_empty_o, out, 1: count <= AE_LEVEL.
- almost_full_o, out, 1: count >= AF_LEVEL.
- count_o, out, ADDR_WIDTH+1: current fill level, 0..DEPTH.
- error_o, out, 1: sticky error flag.
- err_code_o, out, 2: sticky cause; bit0 = overflow, bit1 = underflow.

Behaviour:
- Reset (async assert, sync release): pointers=0, count_o=0, empty_o=1, full_o=0, almost_empty_o=1, almost_full_o=0, rdata_o=0, error_o=0, err_code_o=0. Storage is not reset.
- Pointers:
  - wr_ptr/rd_ptr are ADDR_WIDTH+1 bits; the MSB is the wrap bit.
  - empty when the pointers are equal; full when the low bits are equal and the MSBs differ.
  - Wrap from DEPTH-1 to 0 is natural binary rollover.
- Write acceptance: wr_acc = wr_en_i & (~full_o | rd_acc).
- Read acceptance: rd_acc = rd_en_i & ~empty_o.
- Read timing (standard mode): on rd_acc, rdata_o <= mem[rd_ptr] at that edge, so data is valid the cycle after rd_en_i. rdata_o holds its value when there is no read.
- Write timing: on wr_acc, mem[wr_ptr] <= wdata_i.
- Count update: count_o <= count_o + wr_acc - rd_acc.
- Flags: all flags are derived from the registered next state and update on the same edge as count_o. There are no combinational paths from inputs to outputs.
- Simultaneous read and write:
  - Full: both accepted, count unchanged, no error.
  - Empty: write accepted, read rejected (underflow).
  - Otherwise: both accepted, count unchanged.
- Overflow: wr_en_i & full_o & ~rd_acc → write dropped; error_o <= 1 and err_code_o[0] <= 1.
- Underflow: rd_en_i & empty_o → read ignored, rdata_o unchanged; error_o <= 1 and err_code_o[1] <= 1.
- Error bits are sticky and OR-accumulate.
- err_clr_i clears error_o and err_code_o on the next edge. A new error in the same cycle as err_clr_i wins (its bit is set).
- Reset mid-operation: all state returns to reset values immediately; any in-flight read data is discarded.
- Elaboration checks: AF_LEVEL must be in 1..DEPTH and AE_LEVEL in 0..DEPTH-1; violations give a fatal error.

Optional Feature:
- Macro SYNC_FIFO_FWFT_EN. When defined, the FIFO runs in first-word-fall-through mode:
  - rdata_o always presents mem[rd_ptr] whenever empty_o=0, so a newly written word is visible the cycle after the write into an empty FIFO.
  - rd_en_i pops (acknowledges) the displayed word.
  - Underflow rules are unchanged. rdata_o is undefined-but-stable (holds the last value) when empty.
- When not defined: standard one-cycle registered read as described above.

Decomposition:
- Shared package sync_fifo_pkg holds:
  - typedef fifo_err_t: packed struct {underflow, overflow}, 2 bits.
  - constants ERR_OVF_BIT=0 and ERR_UDF_BIT=1.
  - function clog2_min1, used for ADDR_WIDTH on DEPTH edge cases.
- One sub-module, sync_fifo_ram: DEPTH x WIDTH register array with one write port and one read port (registered or async read selected by parameter for FWFT). It contains the storage only; pointers, flags and errors stay in the top level.
- The bench interface gains err_clr_i, almost_*, count_o and err_code_o in the existing clocking-block style.

Test Plan (WIDTH=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2):
1. Reset, then write 0x11..0x18 on 8 consecutive cycles → count_o goes 1..8; almost_empty_o deasserts at count 3; almost_full_o asserts at count 6; full_o=1 after the 8th write; error_o=0.
2. FIFO full, write 0xAA with no read → count_o stays 8, error_o=1, err_code_o=2'b01. Then read 8 times → rdata_o is 0x11..0x18 in order, each one cycle after its rd_en_i (0xAA never appears).
3. Empty FIFO, rd_en_i=1 → error_o=1, err_code_o=2'b10, rdata_o unchanged. Then err_clr_i=1 → error_o=0 and err_code_o=0 next cycle.
4. Full FIFO, wr_en_i=rd_en_i=1 with wdata 0x55 → count_o stays 8, no error; 0x55 emerges after the remaining 7 older words. Wrap-around: 20 mixed write/read cycles → the scoreboard matches and pointers roll over.
5. Empty FIFO, write+read in the same cycle → write accepted, count_o=1, err_code_o=2'b10. Assert rst_i mid-stream at count 5 → all outputs immediately return to reset values.
6. With SYNC_FIFO_FWFT_EN defined: write 0x3C into the empty FIFO → rdata_o=0x3C and empty_o=0 the next cycle, before any rd_en_i; one rd_en_i pulse → empty_o=1.
